frame_stat: RTL and testbench
=============================

FRAME_STAT -- requirements
Module: frame_stat

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 Parameter FRAME_WIDTH, default 640, pixels per line.
REQ-003 Parameter FRAME_HEIGHT, default 512, lines per frame.
REQ-004 Port clk  input  1  single clock; all logic on posedge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port s_axis  AxiStreamIf.Slave  tdata DATA_WIDTH  pixel input; tuser = start of frame (SOF), tlast = end of line (EOL).
REQ-007 Port m_axis  AxiStreamIf.Master  tdata DATA_WIDTH  pixel pass-through to the downstream contrast LUT stage; tuser and tlast are carried unchanged.
REQ-008 Port stat_valid  output  1  one-cycle pulse when the statistics of a complete frame are valid.
REQ-009 Port stat_min / stat_max  output  DATA_WIDTH  minimum / maximum pixel of the last complete frame.
REQ-010 Port stat_sum  output  SUM_W = DATA_WIDTH + clog2(FRAME_WIDTH*FRAME_HEIGHT)  pixel sum of the last complete frame (27 bits at defaults).
REQ-011 Port err_short_line, err_long_line, err_early_sof, err_no_sof  output  1 each  one-cycle error pulses.

Function
REQ-012 Pass-through: full AXI-Stream handshake; tdata/tuser/tlast SHALL be sent bit-exact, in order, with no loss or duplication.
REQ-013 Latency s_axis to m_axis SHALL be exactly 1 cycle when m_axis.tready is held high; sustained throughput 1 pixel/cycle.
REQ-014 s_axis.tready SHALL be registered; the block buffers up to 2 beats, so m_axis.tready may drop at any cycle with no beat lost.
REQ-015 m_axis.tvalid, once asserted, SHALL hold with stable tdata/tuser/tlast until m_axis.tready is seen.
REQ-016 Statistics SHALL update only on an accepted input beat (s_axis.tvalid && s_axis.tready).
REQ-017 FSM states: WAIT_SOF, IN_FRAME.
REQ-018 WAIT_SOF: an accepted beat with tuser=1 loads col=1, row=0, sum=tdata, min=max=tdata and moves to IN_FRAME; a beat with tuser=0 is passed through, not counted, and pulses err_no_sof.
REQ-019 IN_FRAME: each accepted beat increments col and adds tdata to sum; min/max update by unsigned compare.
REQ-020 tlast with col+1 < FRAME_WIDTH pulses err_short_line; the line still ends at tlast (col=0, row+1).
REQ-021 col reaching FRAME_WIDTH without tlast pulses err_long_line once per line; counting continues until tlast closes the line.
REQ-022 tlast on row FRAME_HEIGHT-1 ends the frame: outputs register the frame values, stat_valid pulses the next cycle, FSM returns to WAIT_SOF.
REQ-023 tuser=1 in IN_FRAME pulses err_early_sof, discards the partial frame (no stat_valid) and restarts accumulation from that beat, as in REQ-018.
REQ-024 A beat carrying both tuser and tlast is handled as a SOF beat followed immediately by an EOL beat.
REQ-025 stat_min/stat_max/stat_sum SHALL hold their values between stat_valid pulses.
REQ-026 sum SHALL never wrap; SUM_W covers 2^DATA_WIDTH-1 times FRAME_WIDTH*FRAME_HEIGHT.

Reset
REQ-027 On rst_n low: FSM=WAIT_SOF; col, row, sum = 0; s_axis.tready=0; m_axis.tvalid/tdata/tuser/tlast = 0; stat_valid=0; stat_min=0; stat_max=0; stat_sum=0; all err_* = 0; skid buffer empty.
REQ-028 s_axis.tready SHALL rise on the first clk edge after reset release.
REQ-029 Reset mid-frame drops all buffered beats and the partial frame; after release the block waits for a fresh SOF.

Structure
REQ-030 Shared package contrast_pkg SHALL hold the FSM state enum and a function that returns SUM_W from its parameters.
REQ-031 Sub-module axis_skid_buffer (2-entry, parameter DATA_WIDTH) SHALL implement REQ-012..015; the statistics logic sits in frame_stat.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=2, DATA_WIDTH=8)
REQ-032 Frame 0..7, SOF on 0, EOL on 3 and 7, tready=1 -> m_axis outputs the same 8 beats 1 cycle later; stat_valid one pulse; min=0, max=7, sum=28.
REQ-033 Same frame with m_axis.tready toggling 1,0,0,1 repeating -> m_axis beat sequence identical; no beat lost; stats identical.
REQ-034 Line 0 has EOL after 3 pixels -> err_short_line pulses once; frame completes after row 1 EOL; sum = sum of the 7 pixels.
REQ-035 SOF at pixel 5 of a frame, then a full frame of 8x 0xFF -> err_early_sof pulses once; one stat_valid only; min=max=255, sum=2040.
REQ-036 3 beats without tuser after reset -> 3 err_no_sof pulses, beats passed through, no stat_valid.
REQ-037 rst_n low during pixel 4, then a clean frame of 10..17 -> no stat_valid for the aborted frame; then min=10, max=17, sum=108.

Source files
------------

// File: rtl/contrast_pkg.sv
// Shared types and sizing helpers for the frame statistics / contrast path.
package contrast_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } fs_state_e;

  // Width of a full-frame pixel sum that can never wrap.
  function automatic int sum_width(input int dw, input int fw, input int fh);
    return dw + $clog2(fw * fh);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer: registered s_tready, 1-cycle latency,
// full throughput, output held stable while stalled.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tuser_i,
  input  logic                  s_tlast_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tuser_o,
  output logic                  m_tlast_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i
);

  localparam int BW = DATA_WIDTH + 2;

  logic [BW-1:0] out_q, out_d, skid_q, skid_d;
  logic          out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, rdy_q;
  logic          in_fire, out_fire;
  logic [BW-1:0] in_beat;

  assign in_beat  = {s_tuser_i, s_tlast_i, s_tdata_i};
  assign in_fire  = s_tvalid_i && rdy_q;
  assign out_fire = out_vld_q && m_tready_i;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (skid_vld_q) begin
      // Upstream is stalled while the skid slot is full; only drain it.
      if (out_fire) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_vld_q || out_fire) begin
        out_d     = in_beat;
        out_vld_d = 1'b1;
      end else begin
        skid_d     = in_beat;
        skid_vld_d = 1'b1;
      end
    end else if (out_fire) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= !skid_vld_d;
    end
  end

  assign s_tready_o = rdy_q;
  assign m_tvalid_o = out_vld_q;
  assign m_tuser_o  = out_q[BW-1];
  assign m_tlast_o  = out_q[BW-2];
  assign m_tdata_o  = out_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/frame_stat.sv
// Video pass-through that gathers per-frame min/max/sum and flags
// line/frame framing errors on the accepted input beats.
module frame_stat
  import contrast_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int FRAME_WIDTH  = 640,
  parameter  int FRAME_HEIGHT = 512,
  localparam int SUM_W        = sum_width(DATA_WIDTH, FRAME_WIDTH, FRAME_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic                  s_axis_tuser_i,
  input  logic                  s_axis_tlast_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tuser_o,
  output logic                  m_axis_tlast_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  stat_valid_o,
  output logic [DATA_WIDTH-1:0] stat_min_o,
  output logic [DATA_WIDTH-1:0] stat_max_o,
  output logic [SUM_W-1:0]      stat_sum_o,
  output logic                  err_short_line_o,
  output logic                  err_long_line_o,
  output logic                  err_early_sof_o,
  output logic                  err_no_sof_o
);

  localparam int CW = $clog2(FRAME_WIDTH) + 1;
  localparam int RW = $clog2(FRAME_HEIGHT) + 1;

  axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tdata_i  (s_axis_tdata_i),
    .s_tuser_i  (s_axis_tuser_i),
    .s_tlast_i  (s_axis_tlast_i),
    .s_tvalid_i (s_axis_tvalid_i),
    .s_tready_o (s_axis_tready_o),
    .m_tdata_o  (m_axis_tdata_o),
    .m_tuser_o  (m_axis_tuser_o),
    .m_tlast_o  (m_axis_tlast_o),
    .m_tvalid_o (m_axis_tvalid_o),
    .m_tready_i (m_axis_tready_i)
  );

  fs_state_e             state_q;
  logic [CW-1:0]         col_q, col_b, col_d;
  logic [RW-1:0]         row_q, row_b;
  logic [SUM_W-1:0]      sum_q, sum_b, sum_d;
  logic [SUM_W:0]        sum_ext;
  logic [DATA_WIDTH-1:0] min_q, min_b, min_d, max_q, max_b, max_d;
  logic                  acc_fire, sof, eol, short_ln, long_ln, last_row;

  logic                  stat_valid_q, err_short_q, err_long_q, err_early_q, err_nosof_q;
  logic [DATA_WIDTH-1:0] stat_min_q, stat_max_q;
  logic [SUM_W-1:0]      stat_sum_q;

  assign acc_fire = s_axis_tvalid_i && s_axis_tready_o;
  assign sof      = s_axis_tuser_i;
  assign eol      = s_axis_tlast_i;

  // A SOF beat accumulates on top of an empty frame, so SOF+EOL on one
  // beat naturally behaves as a SOF immediately followed by an EOL.
  always_comb begin
    col_b    = sof ? '0 : col_q;
    row_b    = sof ? '0 : row_q;
    sum_b    = sof ? '0 : sum_q;
    min_b    = sof ? '1 : min_q;
    max_b    = sof ? '0 : max_q;
    col_d    = (col_b == CW'(FRAME_WIDTH)) ? col_b : col_b + CW'(1);
    sum_ext  = {1'b0, sum_b} + {{(SUM_W + 1 - DATA_WIDTH){1'b0}}, s_axis_tdata_i};
    sum_d    = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    min_d    = (s_axis_tdata_i < min_b) ? s_axis_tdata_i : min_b;
    max_d    = (s_axis_tdata_i > max_b) ? s_axis_tdata_i : max_b;
    short_ln = eol && (col_d < CW'(FRAME_WIDTH));
    long_ln  = !eol && (col_b == CW'(FRAME_WIDTH - 1));
    last_row = (row_b == RW'(FRAME_HEIGHT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_SOF;
      col_q        <= '0;
      row_q        <= '0;
      sum_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      stat_valid_q <= 1'b0;
      stat_min_q   <= '0;
      stat_max_q   <= '0;
      stat_sum_q   <= '0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_early_q  <= 1'b0;
      err_nosof_q  <= 1'b0;
    end else begin
      stat_valid_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_early_q  <= 1'b0;
      err_nosof_q  <= 1'b0;
      if (acc_fire) begin
        if (state_q == WAIT_SOF && !sof) begin
          err_nosof_q <= 1'b1;
        end else begin
          err_early_q <= (state_q == IN_FRAME) && sof;
          err_short_q <= short_ln;
          err_long_q  <= long_ln;
          sum_q       <= sum_d;
          min_q       <= min_d;
          max_q       <= max_d;
          if (eol) begin
            col_q <= '0;
            if (last_row) begin
              stat_valid_q <= 1'b1;
              stat_min_q   <= min_d;
              stat_max_q   <= max_d;
              stat_sum_q   <= sum_d;
              row_q        <= '0;
              sum_q        <= '0;
              state_q      <= WAIT_SOF;
            end else begin
              row_q   <= row_b + RW'(1);
              state_q <= IN_FRAME;
            end
          end else begin
            col_q   <= col_d;
            row_q   <= row_b;
            state_q <= IN_FRAME;
          end
        end
      end
    end
  end

  assign stat_valid_o     = stat_valid_q;
  assign stat_min_o       = stat_min_q;
  assign stat_max_o       = stat_max_q;
  assign stat_sum_o       = stat_sum_q;
  assign err_short_line_o = err_short_q;
  assign err_long_line_o  = err_long_q;
  assign err_early_sof_o  = err_early_q;
  assign err_no_sof_o     = err_nosof_q;

endmodule

// File: tb/tb_frame_stat.sv
// Scoreboard bench for frame_stat at FRAME_WIDTH=4, FRAME_HEIGHT=2, DATA_WIDTH=8.
module tb_frame_stat;
  localparam int DW = 8, FW = 4, FH = 2, SW = 11;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_user = 1'b0, s_last = 1'b0, s_valid = 1'b0, s_ready;
  logic [DW-1:0] m_data;
  logic          m_user, m_last, m_valid, m_ready = 1'b1;
  logic          stat_valid, e_short, e_long, e_early, e_nosof;
  logic [DW-1:0] stat_min, stat_max;
  logic [SW-1:0] stat_sum;

  frame_stat #(.DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata_i(s_data), .s_axis_tuser_i(s_user), .s_axis_tlast_i(s_last),
    .s_axis_tvalid_i(s_valid), .s_axis_tready_o(s_ready),
    .m_axis_tdata_o(m_data), .m_axis_tuser_o(m_user), .m_axis_tlast_o(m_last),
    .m_axis_tvalid_o(m_valid), .m_axis_tready_i(m_ready),
    .stat_valid_o(stat_valid), .stat_min_o(stat_min), .stat_max_o(stat_max),
    .stat_sum_o(stat_sum), .err_short_line_o(e_short), .err_long_line_o(e_long),
    .err_early_sof_o(e_early), .err_no_sof_o(e_nosof)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic u; logic l; int cyc; bit lat; } beat_t;
  typedef struct { logic [DW-1:0] mn; logic [DW-1:0] mx; logic [SW-1:0] sm; } stat_t;

  beat_t exp_q[$];
  stat_t stat_q[$];
  int checks = 0, failures = 0, cyc = 0, rdy_mode = 0, ph = 0;
  int n_short = 0, n_long = 0, n_early = 0, n_nosof = 0, n_stat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Downstream ready: constant high, or the 1,0,0,1 stall pattern.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) m_ready = 1'b1;
    else begin
      m_ready = (ph == 0 || ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  // Monitor: pops scoreboard entries on every output event.
  beat_t         mb;
  stat_t         ms;
  logic          stall_q = 1'b0;
  logic [DW+1:0] stall_beat = '0;
  always @(negedge clk) begin
    if (!rst_n) stall_q = 1'b0;
    else begin
      if (stall_q) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_beat", 64'({m_user, m_last, m_data}), 64'(stall_beat));
      end
      stall_q    = m_valid && !m_ready;
      stall_beat = {m_user, m_last, m_data};
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
        else begin
          mb = exp_q.pop_front();
          chk("tdata", 64'(m_data), 64'(mb.d));
          chk("tuser", 64'(m_user), 64'(mb.u));
          chk("tlast", 64'(m_last), 64'(mb.l));
          if (mb.lat) chk("latency", 64'(cyc - mb.cyc + 1), 64'd1);
        end
      end
      if (stat_valid) begin
        n_stat++;
        if (stat_q.size() == 0) chk("unexpected_stat_valid", 64'd1, 64'd0);
        else begin
          ms = stat_q.pop_front();
          chk("stat_min", 64'(stat_min), 64'(ms.mn));
          chk("stat_max", 64'(stat_max), 64'(ms.mx));
          chk("stat_sum", 64'(stat_sum), 64'(ms.sm));
        end
      end
      if (e_short) n_short++;
      if (e_long)  n_long++;
      if (e_early) n_early++;
      if (e_nosof) n_nosof++;
    end
  end

  // Inputs change 1 time unit after posedge; acceptance decided by s_ready at the edge.
  task automatic send(input logic [DW-1:0] d, input logic u, input logic l);
    bit acc = 0, t;
    s_valid = 1'b1; s_data = d; s_user = u; s_last = l;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk); t = s_ready;
      @(posedge clk); #1;
      if (t) acc = 1;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    else exp_q.push_back('{d, u, l, cyc, rdy_mode == 0});
    s_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("stat_pending", 64'(stat_q.size()), 64'd0);
  endtask

  task automatic clr_cnt();
    n_short = 0; n_long = 0; n_early = 0; n_nosof = 0; n_stat = 0;
  endtask

  task automatic chk_cnt(input string t, input int st, input int sh, input int lg, input int ea, input int ns);
    chk({t, "_stat_valid_cnt"}, 64'(n_stat), 64'(st));
    chk({t, "_err_short_cnt"}, 64'(n_short), 64'(sh));
    chk({t, "_err_long_cnt"}, 64'(n_long), 64'(lg));
    chk({t, "_err_early_cnt"}, 64'(n_early), 64'(ea));
    chk({t, "_err_nosof_cnt"}, 64'(n_nosof), 64'(ns));
  endtask

  task automatic release_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("tready_before_edge", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    chk("tready_after_edge", 64'(s_ready), 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", 64'(s_ready), 64'd0);
    chk("rst_mvalid", 64'(m_valid), 64'd0);
    chk("rst_mdata", 64'({m_user, m_last, m_data}), 64'd0);
    chk("rst_stat", 64'({stat_valid, stat_min, stat_max, stat_sum}), 64'd0);
    chk("rst_err", 64'({e_short, e_long, e_early, e_nosof}), 64'd0);
    release_reset();

    // Clean frame 0..7, ready always high
    clr_cnt();
    stat_q.push_back('{8'd0, 8'd7, 11'd28});
    for (int i = 0; i < 8; i++) send(8'(i), i == 0, i == 3 || i == 7);
    drain();
    chk_cnt("t1", 1, 0, 0, 0, 0);
    chk("hold_min", 64'(stat_min), 64'd0);
    chk("hold_max", 64'(stat_max), 64'd7);
    chk("hold_sum", 64'(stat_sum), 64'd28);

    // Same frame with stalling downstream
    clr_cnt(); rdy_mode = 1; ph = 0;
    stat_q.push_back('{8'd0, 8'd7, 11'd28});
    for (int i = 0; i < 8; i++) send(8'(i), i == 0, i == 3 || i == 7);
    drain();
    rdy_mode = 0;
    chk_cnt("t2", 1, 0, 0, 0, 0);

    // Short first line: 1,2,3 | 4,5,6,7
    clr_cnt();
    stat_q.push_back('{8'd1, 8'd7, 11'd28});
    for (int i = 1; i < 8; i++) send(8'(i), i == 1, i == 3 || i == 7);
    drain();
    chk_cnt("t3", 1, 1, 0, 0, 0);

    // Long first line: 1..5 | 6..9
    clr_cnt();
    stat_q.push_back('{8'd1, 8'd9, 11'd45});
    for (int i = 1; i < 10; i++) send(8'(i), i == 1, i == 5 || i == 9);
    drain();
    chk_cnt("t4", 1, 0, 1, 0, 0);

    // Early SOF after 5 pixels, then a full frame of 0xFF
    clr_cnt();
    stat_q.push_back('{8'd255, 8'd255, 11'd2040});
    for (int i = 0; i < 5; i++) send(8'(i), i == 0, i == 3);
    for (int i = 0; i < 8; i++) send(8'hFF, i == 0, i == 3 || i == 7);
    drain();
    chk_cnt("t5", 1, 0, 0, 1, 0);

    // Reset, then 3 beats without SOF
    @(posedge clk); #1; rst_n = 1'b0; exp_q.delete();
    release_reset();
    clr_cnt();
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    drain();
    chk_cnt("t6", 0, 0, 0, 0, 3);

    // Reset while pixel 4 is being offered, then clean frame 10..17
    clr_cnt();
    for (int i = 0; i < 4; i++) send(8'(i), i == 0, i == 3);
    s_valid = 1'b1; s_data = 8'd4; s_user = 1'b0; s_last = 1'b0;
    rst_n = 1'b0; exp_q.delete();
    @(negedge clk);
    s_valid = 1'b0;
    chk("midrst_sum", 64'(stat_sum), 64'd0);
    chk("midrst_mvalid", 64'(m_valid), 64'd0);
    release_reset();
    stat_q.push_back('{8'd10, 8'd17, 11'd108});
    for (int i = 0; i < 8; i++) send(8'(10 + i), i == 0, i == 3 || i == 7);
    drain();
    chk_cnt("t7", 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
